// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the SRAM-like data interface.
// Accepts req/addr_ok requests, performs them on a word-addressed memory and
// returns data_ok/rdata in order after LATENCY cycles, up to DEPTH outstanding.
module data_sram_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        resp_stall
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WORDS = 1 << ADDR_W;
  localparam logic [3:0]       CNT_INIT = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

  // Backing store; contents are intentionally not reset.
  logic [31:0] mem_q [WORDS];

  // Response queue entries.
  logic        is_wr_q     [DEPTH];
  logic        is_wr_d     [DEPTH];
  logic [31:0] ent_rdata_q [DEPTH];
  logic [31:0] ent_rdata_d [DEPTH];
  logic [3:0]  ent_cnt_q   [DEPTH];
  logic [3:0]  ent_cnt_d   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [ADDR_W-1:0] idx_c;
  logic              push_c;
  logic              pop_c;
  logic              store_c;
  logic [31:0]       rd_word_c;
  logic [31:0]       wr_word_c;
  logic              unused_bits_c;

  assign idx_c         = data_sram_addr[ADDR_W+1:2];
  assign unused_bits_c = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  // Handshake, retire decision and response outputs.
  always_comb begin
    data_sram_addr_ok = ~reset & (count_q != FULL);
    pop_c             = ~reset & (count_q != '0) & (ent_cnt_q[rd_ptr_q] == 4'd0) & ~resp_stall;
    data_sram_data_ok = pop_c;
    data_sram_rdata   = (pop_c & ~is_wr_q[rd_ptr_q]) ? ent_rdata_q[rd_ptr_q] : 32'd0;
    push_c            = data_sram_req & data_sram_addr_ok;
    store_c           = push_c & data_sram_wr;
  end

  // Current word and its byte-lane merge with the store data.
  always_comb begin
    rd_word_c = mem_q[idx_c];
    wr_word_c = rd_word_c;
    for (int b = 0; b < 4; b++) begin
      if (data_sram_wstrb[b]) begin
        wr_word_c[8*b +: 8] = data_sram_wdata[8*b +: 8];
      end
    end
  end

  // Queue next state: countdown, push of a new entry, pointer and count update.
  // Free slots always hold cnt == 0, so counting down every nonzero slot only
  // ever touches live entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      is_wr_d[i]     = is_wr_q[i];
      ent_rdata_d[i] = ent_rdata_q[i];
      ent_cnt_d[i]   = (ent_cnt_q[i] != 4'd0) ? ent_cnt_q[i] - 4'd1 : ent_cnt_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (push_c) begin
      is_wr_d[wr_ptr_q]     = data_sram_wr;
      ent_rdata_d[wr_ptr_q] = data_sram_wr ? 32'd0 : rd_word_c;
      ent_cnt_d[wr_ptr_q]   = CNT_INIT;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Queue state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        is_wr_q[i]     <= 1'b0;
        ent_rdata_q[i] <= 32'd0;
        ent_cnt_q[i]   <= 4'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        is_wr_q[i]     <= is_wr_d[i];
        ent_rdata_q[i] <= ent_rdata_d[i];
        ent_cnt_q[i]   <= ent_cnt_d[i];
      end
    end
  end

  // Memory write port for accepted stores.
  always_ff @(posedge clk) begin
    if (store_c) begin
      mem_q[idx_c] <= wr_word_c;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a LATENCY=2 and a LATENCY=1 instance share the
// stimulus and are each checked against an in-order response-queue model.
module tb_data_sram_responder;

  localparam int unsigned DEPTH = 4;
  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } resp_t;

  logic        clk;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        aok0, dok0, aok1, dok1;
  logic [31:0] rd0, rd1;

  data_sram_responder #(.ADDR_W(10), .DEPTH(DEPTH), .LATENCY(LAT0)) dut (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok0), .data_sram_data_ok(dok0),
    .data_sram_rdata(rd0), .resp_stall(stall)
  );

  data_sram_responder #(.ADDR_W(10), .DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_addr_ok(aok1), .data_sram_data_ok(dok1),
    .data_sram_rdata(rd1), .resp_stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  resp_t       q0[$];
  resp_t       q1[$];
  logic [31:0] mem_m0 [64];
  logic [31:0] mem_m1 [64];
  int          cyc;
  int          total;
  int          bad;
  logic        exp_aok [2];
  logic        exp_dok [2];
  logic [31:0] exp_rd  [2];
  logic        obs_aok [2];
  logic        obs_dok [2];
  logic [31:0] obs_rd  [2];

  // One clock of stimulus: predict, sample mid-cycle, then advance the model.
  task automatic cycle(input logic rq, input logic wr_i, input logic [3:0] strb,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic st, input logic rst);
    int    ix;
    resp_t e;
    req = rq; wr = wr_i; wstrb = strb; addr = a; wdata = wd; stall = st; reset = rst;
    size = 2'($urandom_range(0, 2));
    ix = int'(a[7:2]);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        exp_aok[k] = 1'b0; exp_dok[k] = 1'b0; exp_rd[k] = 32'd0;
      end
    end else begin
      exp_aok[0] = (q0.size() != DEPTH);
      exp_dok[0] = (q0.size() != 0) && (q0[0].due <= cyc) && !st;
      exp_rd[0]  = exp_dok[0] ? q0[0].data : 32'd0;
      exp_aok[1] = (q1.size() != DEPTH);
      exp_dok[1] = (q1.size() != 0) && (q1[0].due <= cyc) && !st;
      exp_rd[1]  = exp_dok[1] ? q1[0].data : 32'd0;
    end
    @(negedge clk);
    obs_aok[0] = aok0; obs_dok[0] = dok0; obs_rd[0] = rd0;
    obs_aok[1] = aok1; obs_dok[1] = dok1; obs_rd[1] = rd1;
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (exp_dok[0]) void'(q0.pop_front());
      if (rq && exp_aok[0]) begin
        e.data = wr_i ? 32'd0 : mem_m0[ix];
        e.due  = cyc + LAT0;
        q0.push_back(e);
        if (wr_i) for (int b = 0; b < 4; b++) if (strb[b]) mem_m0[ix][8*b +: 8] = wd[8*b +: 8];
      end
      if (exp_dok[1]) void'(q1.pop_front());
      if (rq && exp_aok[1]) begin
        e.data = wr_i ? 32'd0 : mem_m1[ix];
        e.due  = cyc + LAT1;
        q1.push_back(e);
        if (wr_i) for (int b = 0; b < 4; b++) if (strb[b]) mem_m1[ix][8*b +: 8] = wd[8*b +: 8];
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 4; n++) begin
      cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, (n < 3));
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL reset dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
    end
    total++;
    if (obs_aok[0] !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_aok got %b want 1", obs_aok[0]);
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 69; i++) begin
      if (i < 64)       cycle(1'b1, 1'b1, 4'hf, 32'(i * 4), $urandom, 1'b0, 1'b0);
      else if (i == 64) cycle(1'b1, 1'b1, 4'hf, 32'h14, 32'hDEADBEEF, 1'b0, 1'b0);
      else              cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL preload dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
    end
  endtask

  task automatic test_single_load();
    int acc, n0, off0, off1;
    logic [31:0] v0;
    acc = cyc; n0 = 0; off0 = -1; off1 = -1; v0 = 32'd0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) cycle(1'b1, 1'b0, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0);
      else        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL single_load dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
      if (obs_dok[0]) begin n0++; off0 = cyc - 1 - acc; v0 = obs_rd[0]; end
      if (obs_dok[1]) off1 = cyc - 1 - acc;
    end
    total++;
    if (n0 != 1 || off0 != 2 || v0 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_load_l2 got count=%0d offset=%0d rdata=%h want count=1 offset=2 rdata=deadbeef",
               n0, off0, v0);
    end
    total++;
    if (off1 != 1) begin
      bad++;
      $display("FAIL single_load_l1 got offset=%0d want 1", off1);
    end
  endtask

  task automatic test_store_then_load();
    int t0;
    int rc[$];
    logic [31:0] rv[$];
    t0 = cyc;
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      cycle(1'b1, 1'b1, 4'b0010, 32'h14, 32'h0000AB00, 1'b0, 1'b0);
      else if (i == 1) cycle(1'b1, 1'b0, 4'h0, 32'h14, 32'h0, 1'b0, 1'b0);
      else             cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL store_load dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
      if (obs_dok[0]) begin rc.push_back(cyc - 1 - t0); rv.push_back(obs_rd[0]); end
    end
    total++;
    if (rc.size() != 2) begin
      bad++;
      $display("FAIL store_load_count got %0d want 2", rc.size());
    end else begin
      total++;
      if (rc[0] != 2 || rv[0] !== 32'd0 || rc[1] != 3 || rv[1] !== 32'hDEADABEF) begin
        bad++;
        $display("FAIL store_load_resp got %0d:%h %0d:%h want 2:00000000 3:deadabef",
                 rc[0], rv[0], rc[1], rv[1]);
      end
    end
  endtask

  task automatic test_full();
    int naok, ndok, first, last;
    naok = 0; ndok = 0; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) cycle(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b1, 1'b0);
      else       cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL full dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
      if (i < 6 && obs_aok[0] === 1'b1) naok++;
      if (obs_dok[0] === 1'b1) begin
        ndok++;
        if (first < 0) first = i;
        last = i;
      end
    end
    total++;
    if (naok != 4) begin
      bad++;
      $display("FAIL full_aok_cycles got %0d want 4", naok);
    end
    total++;
    if (ndok != 4 || first != 6 || last != 9) begin
      bad++;
      $display("FAIL full_drain got count=%0d first=%0d last=%0d want 4 6 9", ndok, first, last);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] base;
    int s;
    int rc[$];
    logic [31:0] rv[$];
    base = $urandom;
    for (int i = 0; i < 50; i++) begin
      if (i < 20)      cycle(1'b1, 1'b1, 4'hf, 32'(i * 4), base + 32'(i), 1'b0, 1'b0);
      else if (i < 24) cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      else if (i < 44) cycle(1'b1, 1'b0, 4'h0, 32'((i - 24) * 4), 32'h0, 1'b0, 1'b0);
      else             cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      if (i == 24) s = cyc - 1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL wrap dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
      if (i >= 24 && obs_dok[0]) begin rc.push_back(cyc - 1 - s); rv.push_back(obs_rd[0]); end
    end
    total++;
    if (rc.size() != 20) begin
      bad++;
      $display("FAIL wrap_count got %0d want 20", rc.size());
    end else begin
      for (int j = 0; j < 20; j++) begin
        total++;
        if (rc[j] != j + LAT0 || rv[j] !== base + 32'(j)) begin
          bad++;
          $display("FAIL wrap_resp%0d got offset=%0d rdata=%h want offset=%0d rdata=%h",
                   j, rc[j], rv[j], j + LAT0, base + 32'(j));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nafter;
    nafter = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 3)       cycle(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0, 1'b1, 1'b0);
      else if (i == 3) cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
      else if (i == 6) cycle(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 1'b0, 1'b0);
      else             cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL reset_mid dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
      if (i >= 3 && i < 6 && (obs_dok[0] === 1'b1 || obs_dok[1] === 1'b1)) nafter++;
      if (i == 4) begin
        total++;
        if (obs_aok[0] !== 1'b1) begin
          bad++;
          $display("FAIL reset_mid_aok got %b want 1", obs_aok[0]);
        end
      end
    end
    total++;
    if (nafter != 0) begin
      bad++;
      $display("FAIL reset_mid_discard got %0d data_ok want 0", nafter);
    end
  endtask

  task automatic test_latency1();
    int n1;
    logic [31:0] r;
    n1 = 0;
    for (int i = 0; i < 18; i++) begin
      r = $urandom;
      if (i < 16) cycle(1'b1, 1'(i % 2), r[3:0], {26'd0, r[9:4]} << 2, $urandom, 1'b0, 1'b0);
      else        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL latency1 dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
      if (i >= 1 && i <= 16 && obs_dok[1] === 1'b1) n1++;
    end
    total++;
    if (n1 != 16) begin
      bad++;
      $display("FAIL latency1_rate got %0d data_ok want 16", n1);
    end
  endtask

  task automatic test_random();
    logic        pend, p_wr, st, rst;
    logic [3:0]  p_strb;
    logic [31:0] p_addr, p_wd, r;
    pend = 1'b0; p_wr = 1'b0; p_strb = 4'h0; p_addr = 32'h0; p_wd = 32'h0;
    for (int i = 0; i < 420; i++) begin
      if (!pend && i < 400 && $urandom_range(0, 3) != 0) begin
        r      = $urandom;
        pend   = 1'b1;
        p_wr   = r[0];
        p_strb = r[4:1];
        p_addr = {r[31:12], 4'b0000, r[10:5], r[2:1]};
        p_wd   = $urandom;
      end
      st  = (i < 400) && ($urandom_range(0, 3) == 0);
      rst = (i < 400) && ($urandom_range(0, 149) == 0);
      cycle(pend, p_wr, p_strb, p_addr, p_wd, st, rst);
      if (pend && exp_aok[0]) pend = 1'b0;
      for (int k = 0; k < 2; k++) begin
        total++;
        if ({obs_aok[k], obs_dok[k], obs_rd[k]} !== {exp_aok[k], exp_dok[k], exp_rd[k]}) begin
          bad++;
          $display("FAIL random dut%0d cyc=%0d got aok=%b dok=%b rdata=%h want aok=%b dok=%b rdata=%h",
                   k, cyc - 1, obs_aok[k], obs_dok[k], obs_rd[k], exp_aok[k], exp_dok[k], exp_rd[k]);
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0; addr = 32'h0; wdata = 32'h0;
    stall = 1'b0; reset = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_preload();
    test_single_load();
    test_store_then_load();
    test_full();
    test_wrap();
    test_reset_mid();
    test_latency1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
